// File: rtl/gcd_pkg.sv
// Shared widths, message types, FSM encoding and test-vector ROMs for the
// GCD self-test subsystem.
package gcd_pkg;

    localparam int W        = 16;
    localparam int NUM_MSGS = 7;
    localparam int IDX_W    = $clog2(NUM_MSGS + 1);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_msg_t;

    typedef logic [W-1:0] resp_msg_t;

    typedef enum logic [1:0] {
        GCD_IDLE = 2'd0,
        GCD_CALC = 2'd1,
        GCD_DONE = 2'd2
    } gcd_state_e;

    // Out-of-range indices return zero; the source and sink never
    // handshake once their index reaches NUM_MSGS.
    function automatic req_msg_t src_rom(input logic [IDX_W-1:0] idx);
        req_msg_t m;
        case (int'(idx))
            0:       m = {W'(27),  W'(15)};
            1:       m = {W'(21),  W'(49)};
            2:       m = {W'(25),  W'(30)};
            3:       m = {W'(19),  W'(27)};
            4:       m = {W'(40),  W'(40)};
            5:       m = {W'(250), W'(190)};
            6:       m = {W'(0),   W'(9)};
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic resp_msg_t ref_rom(input logic [IDX_W-1:0] idx);
        resp_msg_t r;
        case (int'(idx))
            0:       r = W'(3);
            1:       r = W'(7);
            2:       r = W'(5);
            3:       r = W'(1);
            4:       r = W'(40);
            5:       r = W'(10);
            6:       r = W'(9);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gcd_unit.sv
// Subtractive GCD engine: one transaction in flight, datapath advances only
// on cycles where the tick enable is high.
module gcd_unit
    import gcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       req_val,
    output logic       req_rdy,
    input  req_msg_t   req_msg,
    output logic       resp_val,
    input  logic       resp_rdy,
    output resp_msg_t  resp_msg,
    output gcd_state_e state
);

    // Handshake: a transfer happens on a clk edge where val && rdy are both
    // high; val, once raised, holds with a stable message until that edge.
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;

    assign resp_msg = a_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= GCD_IDLE;
            req_rdy  <= 1'b1;
            resp_val <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
        end else begin
            case (state)
                GCD_IDLE: begin
                    if (req_val && req_rdy) begin
                        a_reg   <= req_msg.a;
                        b_reg   <= req_msg.b;
                        req_rdy <= 1'b0;
                        state   <= GCD_CALC;
                    end
                end
                GCD_CALC: begin
                    if (tick) begin
                        if (a_reg < b_reg) begin
                            a_reg <= b_reg;
                            b_reg <= a_reg;
                        end else if (b_reg != '0) begin
                            a_reg <= a_reg - b_reg;
                        end else begin
                            resp_val <= 1'b1;
                            state    <= GCD_DONE;
                        end
                    end
                end
                GCD_DONE: begin
                    if (resp_val && resp_rdy) begin
                        resp_val <= 1'b0;
                        req_rdy  <= 1'b1;
                        state    <= GCD_IDLE;
                    end
                end
                default: begin
                    resp_val <= 1'b0;
                    req_rdy  <= 1'b1;
                    state    <= GCD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/gcd_selftest_top.sv
// Self-checking GCD subsystem: ROM-driven source, divided-tick GCD unit and a
// reference-checking sink with periodic backpressure.
module gcd_selftest_top
    import gcd_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_reset,
    output logic src_done,
    output logic sink_done
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             tick;
    logic [CNT_W-1:0] div_cnt;

    logic             req_val;
    logic             req_rdy;
    req_msg_t         req_msg;
    logic             resp_val;
    logic             resp_rdy;
    resp_msg_t        resp_msg;
    gcd_state_e       gcd_state;

    logic             src_active;
    logic [IDX_W-1:0] src_idx;
    logic [1:0]       bp_cnt;
    logic [IDX_W-1:0] sink_idx;
    logic             sink_err;

    // Divider sits on its own reset so the tick phase is fixed relative to
    // clk_reset release, independent of when the functional reset drops.
    always_ff @(posedge clk or posedge clk_reset) begin
        if (clk_reset) begin
            div_cnt <= '0;
        end else if (div_cnt == CNT_W'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = !clk_reset && (div_cnt == CNT_W'(DIV - 1));

    // src_active keeps req_val low for the first cycle so it is 0 in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_active <= 1'b0;
            src_idx    <= '0;
        end else begin
            src_active <= 1'b1;
            if (req_val && req_rdy) begin
                src_idx <= src_idx + 1'b1;
            end
        end
    end

    assign req_val  = src_active && (src_idx < IDX_W'(NUM_MSGS));
    assign req_msg  = src_rom(src_idx);
    assign src_done = (src_idx == IDX_W'(NUM_MSGS));

    gcd_unit u_gcd (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .state    (gcd_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_cnt   <= '0;
            sink_idx <= '0;
            sink_err <= 1'b0;
        end else begin
            bp_cnt <= bp_cnt + 1'b1;
            if (resp_val && resp_rdy) begin
                if (resp_msg == ref_rom(sink_idx)) begin
                    sink_idx <= sink_idx + 1'b1;
                end else begin
                    sink_err <= 1'b1;
                end
            end
        end
    end

    assign resp_rdy  = (bp_cnt != 2'd3);
    assign sink_done = (sink_idx == IDX_W'(NUM_MSGS)) && !sink_err;

    // The response valid must track the DONE state exactly.
    resp_val_matches_state: assert property (
        @(posedge clk) disable iff (reset) ((gcd_state == GCD_DONE) == resp_val)
    );

endmodule

// File: tb/tb_gcd_selftest_top.sv
// Bench for gcd_selftest_top plus a standalone gcd_unit exercised with
// random operands against a Euclid reference.
module tb_gcd_selftest_top;
    import gcd_pkg::*;

    localparam int DIV        = 2;
    localparam int RUN_BUDGET = 200;

    logic clk = 1'b0;
    logic reset;
    logic clk_reset;
    logic src_done;
    logic sink_done;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    gcd_selftest_top #(.DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_reset (clk_reset),
        .src_done  (src_done),
        .sink_done (sink_done)
    );

    logic       u_reset;
    logic       u_tick;
    logic       u_req_val;
    logic       u_req_rdy;
    req_msg_t   u_req_msg;
    logic       u_resp_val;
    logic       u_resp_rdy;
    resp_msg_t  u_resp_msg;
    gcd_state_e u_state;

    gcd_unit u_unit (
        .clk      (clk),
        .reset    (u_reset),
        .tick     (u_tick),
        .req_val  (u_req_val),
        .req_rdy  (u_req_rdy),
        .req_msg  (u_req_msg),
        .resp_val (u_resp_val),
        .resp_rdy (u_resp_rdy),
        .resp_msg (u_resp_msg),
        .state    (u_state)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        int           ticks;
    } vec_t;

    vec_t vecs[NUM_MSGS];
    vec_t edge_vecs[5];

    function automatic logic [W-1:0] gcd_model(input logic [W-1:0] a, input logic [W-1:0] b);
        int x = int'(a);
        int y = int'(b);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           req_cnt     = 0;
    int           resp_cnt    = 0;
    int           load_cyc    = 0;
    int           lat_ticks   = 0;
    bit           lat_chk_en  = 0;
    bit           prev_stall  = 0;
    bit           prev_rval   = 0;
    logic [W-1:0] prev_msg    = '0;

    always @(negedge clk) begin
        int lat;
        if (reset) begin
            exp_q.delete();
            req_cnt    = 0;
            resp_cnt   = 0;
            prev_stall = 0;
            prev_rval  = 0;
        end else begin
            if (prev_stall) begin
                check("stall_val_held", 32'(dut.resp_val), 32'd1);
                check("stall_msg_stable", 32'(dut.resp_msg), 32'(prev_msg));
            end
            if (lat_chk_en && dut.resp_val && !prev_rval) begin
                lat = cyc - load_cyc;
                check("resp_latency_window",
                      32'(lat >= lat_ticks * DIV - (DIV - 1) && lat <= lat_ticks * DIV), 32'd1);
            end
            if (dut.req_val && dut.req_rdy) begin
                if (req_cnt < NUM_MSGS) begin
                    check("req_msg", 32'(dut.req_msg), {vecs[req_cnt].a, vecs[req_cnt].b});
                    exp_q.push_back(vecs[req_cnt].g);
                    lat_ticks = vecs[req_cnt].ticks;
                end
                load_cyc = cyc + 1;
                req_cnt++;
            end
            if (dut.resp_val && dut.resp_rdy) begin
                check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("resp_msg", 32'(dut.resp_msg), 32'(exp_q.pop_front()));
                end
                resp_cnt++;
            end
            prev_stall = dut.resp_val && !dut.resp_rdy;
            prev_rval  = dut.resp_val;
            prev_msg   = dut.resp_msg;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c = 0;
        while (!sink_done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(sink_done), 32'd1);
    endtask

    task automatic check_full_run(input string tag);
        repeat (20) @(negedge clk);
        check({tag, "_req_count"}, 32'(req_cnt), 32'(NUM_MSGS));
        check({tag, "_resp_count"}, 32'(resp_cnt), 32'(NUM_MSGS));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_sink_err"}, 32'(dut.sink_err), 32'd0);
        check({tag, "_src_done"}, 32'(src_done), 32'd1);
        check({tag, "_idle_handshakes"}, 32'(dut.req_val || dut.resp_val), 32'd0);
    endtask

    task automatic unit_run(input logic [W-1:0] a, input logic [W-1:0] b, input bit rand_tick,
                            output int nticks, output logic [W-1:0] res, output bit seen);
        int c = 0;
        nticks = 0;
        @(negedge clk);
        while (!u_req_rdy && c < 100) begin
            @(negedge clk);
            c++;
        end
        u_req_msg = {a, b};
        u_req_val = 1'b1;
        u_tick    = 1'b0;
        @(negedge clk);
        u_req_val = 1'b0;
        c = 0;
        while (!u_resp_val && c < 4000) begin
            u_tick = rand_tick ? 1'($urandom_range(0, 1)) : 1'b1;
            if (u_tick) nticks++;
            @(negedge clk);
            c++;
        end
        u_tick = 1'b0;
        seen   = u_resp_val;
        res    = u_resp_msg;
        @(negedge clk);
        check("unit_back_to_idle", 32'(u_state == GCD_IDLE && !u_resp_val), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int           src_rise;
        int           sink_rise;
        int           c;
        int           nt;
        logic [W-1:0] res;
        bit           seen;
        gcd_state_e   frz_state;
        logic [W-1:0] frz_a;
        logic [W-1:0] frz_b;

        vecs[0] = '{W'(27),  W'(15),  W'(3),  10};
        vecs[1] = '{W'(21),  W'(49),  W'(7),  9};
        vecs[2] = '{W'(25),  W'(30),  W'(5),  10};
        vecs[3] = '{W'(19),  W'(27),  W'(1),  15};
        vecs[4] = '{W'(40),  W'(40),  W'(40), 3};
        vecs[5] = '{W'(250), W'(190), W'(10), 14};
        vecs[6] = '{W'(0),   W'(9),   W'(9),  2};

        edge_vecs[0] = '{W'(9),  W'(0),  W'(9),  1};
        edge_vecs[1] = '{W'(0),  W'(9),  W'(9),  2};
        edge_vecs[2] = '{W'(40), W'(40), W'(40), 3};
        edge_vecs[3] = '{W'(27), W'(15), W'(3),  10};
        edge_vecs[4] = '{W'(0),  W'(0),  W'(0),  1};

        reset      = 1'b1;
        clk_reset  = 1'b1;
        u_reset    = 1'b1;
        u_tick     = 1'b0;
        u_req_val  = 1'b0;
        u_req_msg  = '0;
        u_resp_rdy = 1'b1;

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_req_val", 32'(dut.req_val), 32'd0);
        check("rst_resp_val", 32'(dut.resp_val), 32'd0);
        check("rst_gcd_state", 32'(dut.u_gcd.state), 32'(GCD_IDLE));
        check("rst_indices", 32'({dut.src_idx, dut.sink_idx}), 32'd0);
        check("rst_tick_low", 32'(dut.tick), 32'd0);

        clk_reset = 1'b0;
        #1;
        for (int k = 1; k <= 30; k++) begin
            check("tick_phase", 32'(dut.tick), 32'((k % DIV) == 0));
            check("done_low_in_reset", 32'(src_done || sink_done), 32'd0);
            @(negedge clk);
            #1;
        end

        // Full run from reset release.
        reset      = 1'b0;
        lat_chk_en = 1'b1;
        src_rise   = -1;
        sink_rise  = -1;
        for (int k = 0; k < RUN_BUDGET && sink_rise < 0; k++) begin
            @(negedge clk);
            if (src_done && src_rise < 0) src_rise = k;
            if (sink_done) sink_rise = k;
        end
        check("run1_sink_done_in_budget", 32'(sink_rise >= 0), 32'd1);
        check("run1_src_before_sink", 32'(src_rise >= 0 && src_rise < sink_rise), 32'd1);
        check_full_run("run1");

        // Freeze the divider while the unit is mid-calculation.
        lat_chk_en = 1'b0;
        run_reset();
        repeat ($urandom_range(5, 40)) @(negedge clk);
        c = 0;
        while (dut.u_gcd.state != GCD_CALC && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("freeze_found_calc", 32'(dut.u_gcd.state), 32'(GCD_CALC));
        clk_reset = 1'b1;
        #1;
        frz_state = dut.u_gcd.state;
        frz_a     = dut.u_gcd.a_reg;
        frz_b     = dut.u_gcd.b_reg;
        repeat ($urandom_range(5, 15)) begin
            @(negedge clk);
            check("freeze_tick_low", 32'(dut.tick), 32'd0);
            check("freeze_state_held", 32'(dut.u_gcd.state), 32'(frz_state));
            check("freeze_operands_held", {dut.u_gcd.a_reg, dut.u_gcd.b_reg}, {frz_a, frz_b});
        end
        clk_reset = 1'b0;
        wait_done(400, "freeze_sink_done");
        check_full_run("freeze");

        // Reset asynchronously after the third response, then rerun.
        lat_chk_en = 1'b1;
        run_reset();
        c = 0;
        while (dut.sink_idx != 3 && c < RUN_BUDGET) begin
            @(negedge clk);
            c++;
        end
        check("midrst_third_resp", 32'(dut.sink_idx), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_flags_clear", 32'(src_done || sink_done), 32'd0);
        check("midrst_vals_clear", 32'(dut.req_val || dut.resp_val), 32'd0);
        check("midrst_indices_clear", 32'({dut.src_idx, dut.sink_idx}), 32'd0);
        check("midrst_gcd_idle", 32'(dut.u_gcd.state), 32'(GCD_IDLE));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_done(RUN_BUDGET, "midrst_sink_done");
        check_full_run("midrst");

        // Standalone unit: edge operands with a tick every cycle.
        u_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            unit_run(edge_vecs[i].a, edge_vecs[i].b, 1'b0, nt, res, seen);
            check("edge_resp_seen", 32'(seen), 32'd1);
            check("edge_result", 32'(res), 32'(edge_vecs[i].g));
            check("edge_ticks", 32'(nt), 32'(edge_vecs[i].ticks));
        end

        // Standalone unit: random operands and random tick pattern.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            unit_run(ra, rb, 1'b1, nt, res, seen);
            check("rand_resp_seen", 32'(seen), 32'd1);
            check("rand_result", 32'(res), 32'(gcd_model(ra, rb)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
